// File: rtl/pwm_compare_stage.sv
// pwm_compare_stage
// Turns the sampled value of a free-running up counter into a registered PWM
// output. Duty requests arrive over a valid/ready handshake and are applied
// only at a counter wrap (MAX -> 0), so a period is never cut short or
// stretched mid-way. The stage also pulses on every wrap, counts the periods
// generated while running, and latches a sticky flag whenever the counter
// fails to advance by exactly one.

module pwm_compare_stage #(
    parameter int WIDTH  = 4,
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              enable,
    input  logic [WIDTH-1:0]  duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              pwm_out,
    output logic              wrap_pulse,
    output logic [PCNT_W-1:0] period_count,
    output logic              seq_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
    localparam logic [WIDTH-1:0]  CNT_ZERO = '0;
    localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [PCNT_W-1:0] PCNT_ONE = 1;

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   cnt_q;
    logic               primed;
    logic [WIDTH-1:0]   cnt_step;

    logic [WIDTH-1:0]   active_duty;
    logic [WIDTH-1:0]   shadow;
    logic               pending;
    logic [WIDTH-1:0]   duty_eff;

    logic               wrap;
    logic               step_bad;
    logic               duty_xfer;
    logic               leave_to_idle;
    logic               run_next;
    logic               pwm_next;

    // A wrap is only trusted once a previous counter sample exists.
    always_comb begin
        cnt_step = cnt_q + CNT_ONE;
        wrap     = primed && (cnt_q == CNT_MAX) && (count_in == CNT_ZERO);
        step_bad = primed && (count_in != cnt_step);
    end

    // Next-state selection; dropping enable always wins over a wrap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake qualifiers and the duty value the comparator should use now.
    always_comb begin
        duty_xfer     = duty_valid && duty_ready;
        leave_to_idle = (state != IDLE) && (state_next == IDLE);
        run_next      = (state_next == RUN);
        duty_eff      = (wrap && pending) ? shadow : active_duty;
        pwm_next      = run_next && (count_in < duty_eff);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Keep one cycle of counter history for wrap and step checking.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= CNT_ZERO;
            primed <= 1'b0;
        end else begin
            cnt_q  <= count_in;
            primed <= 1'b1;
        end
    end

    // Duty bookkeeping: direct load when idle, otherwise park the request in
    // the shadow register until the next wrap (or until the stage goes idle).
    always_ff @(posedge clk) begin
        if (reset) begin
            active_duty <= CNT_ZERO;
            shadow      <= CNT_ZERO;
            pending     <= 1'b0;
            duty_ready  <= 1'b1;
        end else if (state == IDLE) begin
            if (duty_xfer) begin
                active_duty <= duty_in;
            end
            duty_ready <= 1'b1;
        end else if (leave_to_idle) begin
            if (duty_xfer) begin
                active_duty <= duty_in;
            end else if (pending) begin
                active_duty <= shadow;
            end
            pending    <= 1'b0;
            duty_ready <= 1'b1;
        end else if (wrap && pending) begin
            active_duty <= shadow;
            pending     <= 1'b0;
            duty_ready  <= 1'b1;
        end else if (duty_xfer) begin
            shadow     <= duty_in;
            pending    <= 1'b1;
            duty_ready <= 1'b0;
        end
    end

    // Registered PWM and wrap pulse, one cycle behind count_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out    <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            pwm_out    <= pwm_next;
            wrap_pulse <= wrap;
        end
    end

    // Count wraps that start or continue a running period.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_count <= '0;
        end else if (wrap && run_next) begin
            period_count <= period_count + PCNT_ONE;
        end
    end

    // Sticky flag for any counter step other than +1 modulo the period.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_error <= 1'b0;
        end else if (step_bad) begin
            seq_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_compare_stage.sv
// tb_pwm_compare_stage
// Drives a mostly free-running counter with random duty requests and enable
// changes, and compares every registered output each cycle against a
// period-level reference model of the PWM stage.

module tb_pwm_compare_stage;

    localparam int WIDTH  = 4;
    localparam int PCNT_W = 8;
    localparam int PERIOD = 16;
    localparam int PCNT_MOD = 256;

    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_RUN  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [WIDTH-1:0]  count_in = '0;
    logic              enable = 1'b0;
    logic [WIDTH-1:0]  duty_in = '0;
    logic              duty_valid = 1'b0;
    logic              duty_ready;
    logic              pwm_out;
    logic              wrap_pulse;
    logic [PCNT_W-1:0] period_count;
    logic              seq_error;

    int testsRun = 0;
    int testsFailed = 0;
    int cnt = 0;

    int mode = M_IDLE;
    int curDuty = 0;
    int heldDuty = 0;
    int hasHeld = 0;
    int lastCount = -1;
    int expPwm = 0;
    int expWrap = 0;
    int expPeriods = 0;
    int expErr = 0;
    int expReady = 1;

    pwm_compare_stage #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .count_in     (count_in),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .wrap_pulse   (wrap_pulse),
        .period_count (period_count),
        .seq_error    (seq_error)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: what the stage should show after the coming edge.
    task automatic modelStep();
        int  now;
        int  nextMode;
        int  dutyNow;
        bit  isWrap;
        bit  accepted;
        if (reset) begin
            mode = M_IDLE; curDuty = 0; heldDuty = 0; hasHeld = 0;
            lastCount = -1; expPwm = 0; expWrap = 0; expPeriods = 0;
            expErr = 0; expReady = 1;
            return;
        end
        now = int'(count_in);
        isWrap = (lastCount == PERIOD - 1) && (now == 0);
        accepted = duty_valid && (expReady != 0);
        if (!enable)
            nextMode = M_IDLE;
        else if (mode == M_IDLE)
            nextMode = M_SYNC;
        else if (mode == M_SYNC && isWrap)
            nextMode = M_RUN;
        else
            nextMode = mode;
        dutyNow = (isWrap && hasHeld != 0) ? heldDuty : curDuty;
        expPwm = (nextMode == M_RUN && now < dutyNow) ? 1 : 0;
        expWrap = isWrap ? 1 : 0;
        if (isWrap && nextMode == M_RUN)
            expPeriods = (expPeriods + 1) % PCNT_MOD;
        if (lastCount >= 0 && now != (lastCount + 1) % PERIOD)
            expErr = 1;
        if (mode == M_IDLE) begin
            if (accepted) curDuty = int'(duty_in);
        end else if (nextMode == M_IDLE) begin
            if (accepted) curDuty = int'(duty_in);
            else if (hasHeld != 0) curDuty = heldDuty;
            hasHeld = 0;
            expReady = 1;
        end else if (isWrap && hasHeld != 0) begin
            curDuty = heldDuty;
            hasHeld = 0;
            expReady = 1;
        end else if (accepted) begin
            heldDuty = int'(duty_in);
            hasHeld = 1;
            expReady = 0;
        end
        mode = nextMode;
        lastCount = now;
    endtask

    // One clock: advance the model, take the edge, compare all outputs.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("pwm_out", int'(pwm_out), expPwm);
        checkOutput("wrap_pulse", int'(wrap_pulse), expWrap);
        checkOutput("period_count", int'(period_count), expPeriods);
        checkOutput("seq_error", int'(seq_error), expErr);
        checkOutput("duty_ready", int'(duty_ready), expReady);
    endtask

    task automatic runCycles(input int n, input bit en, input int validPct, input int jumpAt = -1);
        for (int i = 0; i < n; i++) begin
            count_in   = cnt[WIDTH-1:0];
            enable     = en;
            duty_valid = ($urandom_range(99) < validPct);
            duty_in    = WIDTH'($urandom_range(PERIOD - 1));
            applyStimulus();
            cnt = (cnt + 1) % PERIOD;
            if (i == jumpAt) cnt = (cnt + 2) % PERIOD;
        end
    endtask

    task automatic sendDuty(input int value, input bit en);
        count_in   = cnt[WIDTH-1:0];
        enable     = en;
        duty_valid = 1'b1;
        duty_in    = WIDTH'(value);
        applyStimulus();
        cnt = (cnt + 1) % PERIOD;
    endtask

    initial begin
        reset = 1'b1;
        runCycles(2, 1'b0, 0);
        reset = 1'b0;

        sendDuty(4, 1'b0);
        runCycles(40, 1'b0, 30);

        while (cnt != 5) runCycles(1, 1'b0, 0);
        sendDuty(4, 1'b0);
        runCycles(60, 1'b1, 0);
        while (cnt != 7) runCycles(1, 1'b1, 0);
        sendDuty(10, 1'b1);
        runCycles(50, 1'b1, 0);
        runCycles(150, 1'b1, 10);

        sendDuty(0, 1'b1);
        runCycles(40, 1'b1, 0);
        sendDuty(15, 1'b1);
        runCycles(40, 1'b1, 0);

        for (int k = 0; k < 20; k++)
            runCycles(int'($urandom_range(40, 5)), 1'($urandom_range(1)), 20);

        while (cnt != 4) runCycles(1, 1'b1, 0);
        runCycles(10, 1'b1, 0, 2);
        runCycles(40, 1'b1, 10);

        reset = 1'b1;
        runCycles(1, 1'b1, 0);
        reset = 1'b0;
        runCycles(20, 1'b1, 0);

        runCycles(258 * PERIOD + 20, 1'b1, 2);

        while (cnt != 0) runCycles(1, 1'b1, 5);
        runCycles(1, 1'b0, 0);
        runCycles(20, 1'b0, 20);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
